// File: rtl/regfile_write_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : y86_pkg
//  Description : Shared constants and types for the Y86 write-back path.
//                Provides the register-index type, the "no register"
//                encoding, the stack-pointer index and the datapath width.
//  Revision    : 1.0 - initial release
// ============================================================================
package y86_pkg;

  localparam int DATA_W = 64;

  typedef logic [3:0] reg_idx_t;

  localparam reg_idx_t RNONE = 4'hF;
  localparam reg_idx_t RSP   = 4'h4;

endpackage : y86_pkg
`default_nettype wire

// File: rtl/regfile_write_scheduler_wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wb_fifo
//  Description : Write-back request FIFO with two push ports and one pop
//                port. push0 is the older of two same-cycle pushes and lands
//                ahead of push1. flush_i discards all contents synchronously.
//  Ports       : clk, rst_n          - clock, async active-low reset
//                flush_i             - drop all entries at next edge
//                push0_i/push0_data_i - older push
//                push1_i/push1_data_i - younger push
//                pop_i               - remove head entry
//                head_o              - current head entry
//                count_o             - number of valid entries
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo #(
  parameter  int DEPTH = 4,   // power of two, >= 2
  parameter  int W     = 68,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          push0_i,
  input  logic [W-1:0]  push0_data_i,
  input  logic          push1_i,
  input  logic [W-1:0]  push1_data_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] w_wr_ptr_p1;

  // Pointer arithmetic wraps naturally because DEPTH is a power of two.
  assign w_wr_ptr_p1 = wr_ptr_q + PW'(1);

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push0_i) + PW'(push1_i);
    rd_ptr_d = rd_ptr_q + PW'(pop_i);
    count_d  = count_q + CW'(push0_i) + CW'(push1_i) - CW'(pop_i);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset: an entry is only ever read after being written.
  // A lone push1 takes the slot push0 would have used.
  always_ff @(posedge clk) begin
    if (!flush_i) begin
      if (push0_i) mem_q[wr_ptr_q] <= push0_data_i;
      if (push1_i) mem_q[push0_i ? w_wr_ptr_p1 : wr_ptr_q] <= push1_data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule : wb_fifo
`default_nettype wire

// File: rtl/regfile_write_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_scheduler
//  Description : Serialises E-port and M-port write-backs onto the single
//                register-file write port in program order (E older than M),
//                and tracks per-register pending writes for hazard stalls.
//  Ports       : clk, rst_n                     - clock, async active-low reset
//                e_valid_i/e_dst_i/e_data_i     - E-port request (valE)
//                m_valid_i/m_dst_i/m_data_i     - M-port request (valM)
//                in_ready_o                     - room for two requests
//                hold_i                         - suppress issue this cycle
//                flush_i                        - discard queued writes
//                wr_en_o/wr_dst_o/wr_data_o     - registered write port
//                rd_a_i/rd_b_i                  - decode read addresses
//                rd_a_pending_o/rd_b_pending_o  - RAW hazard indications
//                pending_mask_o                 - per-register pending bits
//                idle_o                         - nothing queued or issuing
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_scheduler
  import y86_pkg::*;
#(
  parameter int DATA_W = y86_pkg::DATA_W,
  parameter int NREG   = 15,
  parameter int DEPTH  = 4     // power of two, >= 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              e_valid_i,
  input  logic [3:0]        e_dst_i,
  input  logic [DATA_W-1:0] e_data_i,
  input  logic              m_valid_i,
  input  logic [3:0]        m_dst_i,
  input  logic [DATA_W-1:0] m_data_i,
  output logic              in_ready_o,
  input  logic              hold_i,
  input  logic              flush_i,
  output logic              wr_en_o,
  output logic [3:0]        wr_dst_o,
  output logic [DATA_W-1:0] wr_data_o,
  input  logic [3:0]        rd_a_i,
  input  logic [3:0]        rd_b_i,
  output logic              rd_a_pending_o,
  output logic              rd_b_pending_o,
  output logic [NREG-1:0]   pending_mask_o,
  output logic              idle_o
);

  localparam int EW    = DATA_W + 4;
  localparam int CW    = $clog2(DEPTH + 1);
  // Queued entries plus the one in the write register.
  localparam int SB_CW = $clog2(DEPTH + 2);

  logic [CW-1:0]     w_count;
  logic [EW-1:0]     w_head;
  logic              w_e_push;
  logic              w_m_push;
  logic              w_pop;

  logic              wr_en_q;
  logic [3:0]        wr_dst_q;
  logic [DATA_W-1:0] wr_data_q;

  // Two free slots guarantee a simultaneous E+M pair always fits.
  assign in_ready_o = (w_count <= CW'(DEPTH - 2));

  assign w_e_push = in_ready_o && !flush_i && e_valid_i && (e_dst_i != RNONE);
  assign w_m_push = in_ready_o && !flush_i && m_valid_i && (m_dst_i != RNONE);
  assign w_pop    = (w_count != '0) && !hold_i && !flush_i;

  wb_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_i),
    .push0_i      (w_e_push),
    .push0_data_i ({e_dst_i, e_data_i}),
    .push1_i      (w_m_push),
    .push1_data_i ({m_dst_i, m_data_i}),
    .pop_i        (w_pop),
    .head_o       (w_head),
    .count_o      (w_count)
  );

  // Issue register: one write per cycle, no bypass from the inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_dst_q  <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= w_pop;
      if (w_pop) begin
        wr_dst_q  <= w_head[EW-1:DATA_W];
        wr_data_q <= w_head[DATA_W-1:0];
      end
    end
  end

  assign wr_en_o   = wr_en_q;
  assign wr_dst_o  = wr_dst_q;
  assign wr_data_o = wr_data_q;

  // Per-register pending counters. A counter stays non-zero until its last
  // write has actually been presented on the write port.
  for (genvar r = 0; r < NREG; r++) begin : g_sb
    logic [SB_CW-1:0] cnt_q;
    logic [SB_CW-1:0] cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (w_e_push && (e_dst_i == 4'(r)))  cnt_d = cnt_d + SB_CW'(1);
      if (w_m_push && (m_dst_i == 4'(r)))  cnt_d = cnt_d + SB_CW'(1);
      if (wr_en_q && (wr_dst_q == 4'(r)))  cnt_d = cnt_d - SB_CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (flush_i) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign pending_mask_o[r] = (cnt_q != '0);
  end

  // Extend to 16 entries so RNONE indexes a constant-zero bit.
  logic [15:0] w_mask16;
  assign w_mask16 = 16'(pending_mask_o);

  assign rd_a_pending_o = (rd_a_i != RNONE) && w_mask16[rd_a_i];
  assign rd_b_pending_o = (rd_b_i != RNONE) && w_mask16[rd_b_i];

  assign idle_o = (w_count == '0) && !wr_en_q;

endmodule : regfile_write_scheduler
`default_nettype wire

// File: doc/regfile_write_scheduler.md
Name: regfile_write_scheduler

Overview:
- Serialises register write-backs onto the register file's single write port.
- Inputs: two producers per cycle, the E-port (valE result) and the M-port (valM load/pop result).
- Buffers requests in program order in a small FIFO and issues at most one write per cycle.
- Keeps a per-register pending scoreboard so decode can stall on read-after-write hazards. Sits between execute/memory write-back and the register file.

Parameters:
- DATA_W, 64, write data width.
- NREG, 15, architectural registers 0..14; dst 4'hF = RNONE.
- DEPTH, 4, FIFO entries; must be >= 2 and a power of two.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- e_valid  input  1  E-port write request.
- e_dst  input  4  E-port destination register.
- e_data  input  DATA_W  E-port data (valE).
- m_valid  input  1  M-port write request.
- m_dst  input  4  M-port destination register.
- m_data  input  DATA_W  M-port data (valM).
- in_ready  output  1  at least 2 free FIFO slots; both ports may be presented.
- hold  input  1  register file busy; suppress issue this cycle.
- flush  input  1  synchronous discard of all queued writes.
- wr_en  output  1  registered write strobe to register file.
- wr_dst  output  4  registered write address.
- wr_data  output  DATA_W  registered write data.
- rd_a  input  4  decode read address A.
- rd_b  input  4  decode read address B.
- rd_a_pending  output  1  rd_a has an unissued or in-flight write (0 for RNONE).
- rd_b_pending  output  1  same for rd_b.
- pending_mask  output  NREG  bit r set while register r has any queued write.
- idle  output  1  FIFO empty and wr_en low.

Behaviour:
Reset:
- Asynchronous on rst_n low: FIFO count=0, pointers=0, all pending counters=0, wr_en=0, wr_dst=0, wr_data=0.
- Consequently in_ready=1, idle=1, pending_mask=0.
- Reset mid-drain discards queued writes; none are issued.

Enqueue (rising edge, only when in_ready=1):
- Accept e_valid and m_valid; a request with dst=4'hF is dropped and never enqueued.
- Both valid in the same cycle: E entry is written first (older), then M (younger). popq %rsp therefore ends with valM in rsp.
- Requests presented while in_ready=0 are ignored; the producer must hold them.

Issue:
- Each cycle with count>0 and hold=0: pop the head entry and register it onto wr_en/wr_dst/wr_data. Otherwise wr_en=0 next cycle.
- Minimum latency: request at edge N, wr_en high in the cycle after edge N+1 (one registered stage, no bypass).
- Enqueue and issue in the same cycle are both honoured; count changes by enqueues minus 1.
- Pointers wrap modulo DEPTH. Count never exceeds DEPTH, guaranteed by in_ready.

Scoreboard:
- Per-register counter, width clog2(DEPTH+2).
- Increment on enqueue to that register; two increments when E and M target the same register.
- Decrement when the issued write to that register retires, i.e. the cycle wr_en is high.
- Simultaneous increment and decrement on one register nets correctly.
- pending_mask[r] = counter[r] != 0.
- rd_x_pending is combinational from rd_x and pending_mask.

Flush:
- Synchronous. Next edge: count=0, all counters=0, wr_en=0. Enqueues presented in the flush cycle are dropped.
- Flush has priority over enqueue and issue; rst_n has priority over everything.

Decomposition:
- Shared package y86_pkg: RNONE=4'hF, RSP=4'h4, register-index type, DATA_W constant.
- Natural sub-module wb_fifo: parameterised DEPTH FIFO with dual-push (push0 older, push1 younger), single pop, count output, flush.
- Scoreboard counters and issue register stay in the top module.

Test Plan:
- Reset, then single E write dst=3 data=0x10 -> wr_en high next cycle with wr_dst=3, wr_data=0x10; pending_mask[3] high during the queued cycle, 0 after retire; idle returns to 1.
- popq style: E dst=4 data=0x1F8 and M dst=2 data=0xAB in the same cycle -> two consecutive writes, (4,0x1F8) then (2,0xAB); popq %rsp variant with both dst=4 -> final write 4=M data; pending counter[4] reaches 2 and decays to 0.
- RNONE: e_dst=4'hF with m_dst=5 -> only the register 5 write is issued; rd_a=4'hF gives rd_a_pending=0.
- Back-pressure: hold=1 while presenting pairs each cycle -> after 2 pairs in_ready=0 and further requests are ignored; release hold -> 4 writes drain in order, one per cycle.
- Flush with 3 entries queued -> no further wr_en, pending_mask=0 next cycle; then async rst_n pulse mid-drain -> outputs zero immediately, asynchronously.
